// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for the unified-memory port arbiter.
//   arb_state_e  : arbiter FSM states (IDLE / ISSUE / WAIT)
//   arb_owner_e  : which requester owns the transaction in flight
//   mem_req_t    : latched memory request (addr, we, wstrb, wdata)
//   STRB_ALL     : full-word byte strobe
package mem_arb_pkg;

    // Address field width of the latched request. The top-level ADDR_WIDTH
    // must not exceed this value.
    localparam int REQ_ADDR_W = 32;

    localparam logic [3:0] STRB_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  we;
        logic [3:0]            wstrb;
        logic [31:0]           wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and memory buses of the arbiter.
//   fetch : i_req_valid/i_req_addr/i_req_ready, i_flush, i_resp_valid/i_resp_data
//   data  : d_req_valid/addr/we/wstrb/wdata/ready, d_resp_valid/d_resp_data
//   memory: m_req_valid/addr/we/wstrb/wdata, m_req_ready, m_resp_valid/m_resp_data
//   debug : dbg_state (arbiter FSM state)
// modport slave  : the arbiter itself
// modport master : the surrounding environment (fetch, mem stage, memory)
//
// Handshake semantics: a request transfers on a rising clock edge where both
// valid and ready are high. Ready may depend combinationally on valid; the
// request fields must be stable while valid is high. Response valids are
// single-cycle pulses with no back-pressure.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_req_ready;
    logic                  i_flush;
    logic                  i_resp_valid;
    logic [31:0]           i_resp_data;

    logic                  d_req_valid;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_req_we;
    logic [3:0]            d_req_wstrb;
    logic [31:0]           d_req_wdata;
    logic                  d_req_ready;
    logic                  d_resp_valid;
    logic [31:0]           d_resp_data;

    logic                  m_req_valid;
    logic [ADDR_WIDTH-1:0] m_req_addr;
    logic                  m_req_we;
    logic [3:0]            m_req_wstrb;
    logic [31:0]           m_req_wdata;
    logic                  m_req_ready;
    logic                  m_resp_valid;
    logic [31:0]           m_resp_data;

    arb_state_e            dbg_state;

    modport slave (
        input  i_req_valid, i_req_addr, i_flush,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wstrb, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output m_req_valid, m_req_addr, m_req_we, m_req_wstrb, m_req_wdata,
        input  m_req_ready, m_resp_valid, m_resp_data,
        output dbg_state
    );

    modport master (
        output i_req_valid, i_req_addr, i_flush,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_addr, d_req_we, d_req_wstrb, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  m_req_valid, m_req_addr, m_req_we, m_req_wstrb, m_req_wdata,
        output m_req_ready, m_resp_valid, m_resp_data,
        input  dbg_state
    );

endinterface

// File: rtl/mem_port_arbiter_priority_select.sv
// arb_priority_select: combinational winner selection between fetch and data
// requests, plus the saturating data-streak counter that bounds fetch starvation.
//   clk, reset_n    : clock, asynchronous active-low reset
//   idle_i          : arbiter can accept a request this cycle
//   i_req_valid_i   : fetch request pending
//   i_flush_i       : fetch flush (blocks a fetch grant this cycle)
//   d_req_valid_i   : data request pending
//   grant_i_o       : fetch request granted
//   grant_d_o       : data request granted
module arb_priority_select #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic idle_i,
    input  logic i_req_valid_i,
    input  logic i_flush_i,
    input  logic d_req_valid_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;
    logic          at_max;
    logic          data_win;

    assign at_max = (streak_q == SW'(MAX_DATA_STREAK));

    // Data wins unless fetch is waiting and has already been passed over
    // MAX_DATA_STREAK times in a row.
    assign data_win  = d_req_valid_i && !(i_req_valid_i && at_max);
    assign grant_d_o = idle_i && data_win;
    assign grant_i_o = idle_i && !data_win && i_req_valid_i && !i_flush_i;

    // The streak only counts data grants that fetch actually had to wait for.
    always_comb begin
        streak_d = streak_q;
        if (!i_req_valid_i || grant_i_o) begin
            streak_d = '0;
        end else if (grant_d_o && !at_max) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port and
// the data port. One transaction at a time: accept (IDLE), present to memory
// (ISSUE), wait for the response (WAIT), then pulse the owner's response.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : mem_port_arbiter_if.slave (fetch, data and memory buses)
//   busy         : FSM is not in IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    mem_req_t    req_q, req_d;
    logic        cancel_q, cancel_d;
    logic        i_resp_valid_q, i_resp_valid_d;
    logic [31:0] i_resp_data_q, i_resp_data_d;
    logic        d_resp_valid_q, d_resp_valid_d;
    logic [31:0] d_resp_data_q, d_resp_data_d;
    logic        arb_idle;
    logic        grant_i;
    logic        grant_d;

    // Gating with reset_n keeps both readies low while reset is held.
    assign arb_idle = (state_q == ST_IDLE) && reset_n;

    arb_priority_select #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_select (
        .clk          (clk),
        .reset_n      (reset_n),
        .idle_i       (arb_idle),
        .i_req_valid_i(bus.i_req_valid),
        .i_flush_i    (bus.i_flush),
        .d_req_valid_i(bus.d_req_valid),
        .grant_i_o    (grant_i),
        .grant_d_o    (grant_d)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        req_d          = req_q;
        cancel_d       = cancel_q;
        i_resp_valid_d = 1'b0;
        i_resp_data_d  = i_resp_data_q;
        d_resp_valid_d = 1'b0;
        d_resp_data_d  = d_resp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    req_d.addr  = REQ_ADDR_W'(bus.d_req_addr);
                    req_d.we    = bus.d_req_we;
                    req_d.wstrb = bus.d_req_wstrb;
                    req_d.wdata = bus.d_req_wdata;
                    owner_d     = OWN_DATA;
                    state_d     = ST_ISSUE;
                end else if (grant_i) begin
                    req_d.addr  = REQ_ADDR_W'(bus.i_req_addr);
                    req_d.we    = 1'b0;
                    req_d.wstrb = 4'h0;
                    req_d.wdata = 32'h0;
                    owner_d     = OWN_FETCH;
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (bus.m_req_ready) begin
                    state_d = ST_WAIT;
                end
                if (owner_q == OWN_FETCH && bus.i_flush) begin
                    cancel_d = 1'b1;
                end
            end

            ST_WAIT: begin
                if (bus.m_resp_valid) begin
                    state_d  = ST_IDLE;
                    owner_d  = OWN_NONE;
                    cancel_d = 1'b0;
                    if (owner_q == OWN_DATA) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = req_q.we ? 32'h0 : bus.m_resp_data;
                    end else if (owner_q == OWN_FETCH) begin
                        // A flush arriving with the response still squashes it.
                        if (!cancel_q && !bus.i_flush) begin
                            i_resp_valid_d = 1'b1;
                            i_resp_data_d  = bus.m_resp_data;
                        end
                    end
                end else if (owner_q == OWN_FETCH && bus.i_flush) begin
                    cancel_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_NONE;
            req_q          <= '0;
            cancel_q       <= 1'b0;
            i_resp_valid_q <= 1'b0;
            i_resp_data_q  <= 32'h0;
            d_resp_valid_q <= 1'b0;
            d_resp_data_q  <= 32'h0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            req_q          <= req_d;
            cancel_q       <= cancel_d;
            i_resp_valid_q <= i_resp_valid_d;
            i_resp_data_q  <= i_resp_data_d;
            d_resp_valid_q <= d_resp_valid_d;
            d_resp_data_q  <= d_resp_data_d;
        end
    end

    assign bus.i_req_ready  = grant_i;
    assign bus.d_req_ready  = grant_d;
    assign bus.i_resp_valid = i_resp_valid_q;
    assign bus.i_resp_data  = i_resp_data_q;
    assign bus.d_resp_valid = d_resp_valid_q;
    assign bus.d_resp_data  = d_resp_data_q;

    // ISSUE is only entered from a registered transition, so m_req_valid
    // comes straight from the state flops and rises the cycle after acceptance.
    assign bus.m_req_valid  = (state_q == ST_ISSUE);
    assign bus.m_req_addr   = ADDR_WIDTH'(req_q.addr);
    assign bus.m_req_we     = req_q.we;
    assign bus.m_req_wstrb  = req_q.wstrb;
    assign bus.m_req_wdata  = req_q.wdata;

    assign bus.dbg_state    = state_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage's instruction port and the memory-access stage's data port.
- Accepts one request at a time from either requester, issues it to memory, and waits for the response. It then routes the response back to the requester that owns it.
- Data requests win by default. A streak counter stops fetch from being starved. A fetch flush (mispredict or jalr redirect) cancels an outstanding fetch response.

Parameters:
- ADDR_WIDTH, 32, width of every address bus
- MAX_DATA_STREAK, 4, number of consecutive data grants allowed while fetch is waiting (must be 1 or more)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- i_req_valid  input  1  fetch request valid
- i_req_addr  input  ADDR_WIDTH  fetch word address
- i_req_ready  output  1  fetch request accepted this cycle
- i_flush  input  1  cancel the outstanding or in-flight fetch
- i_resp_valid  output  1  fetch data valid (one-cycle pulse)
- i_resp_data  output  32  fetched instruction
- d_req_valid  input  1  data request valid
- d_req_addr  input  ADDR_WIDTH  data address
- d_req_we  input  1  1 = store, 0 = load
- d_req_wstrb  input  4  byte write strobes
- d_req_wdata  input  32  store data
- d_req_ready  output  1  data request accepted this cycle
- d_resp_valid  output  1  load data or store acknowledge (one-cycle pulse)
- d_resp_data  output  32  load data; 0 for stores
- m_req_valid  output  1  request to memory
- m_req_addr  output  ADDR_WIDTH  memory address
- m_req_we, m_req_wstrb, m_req_wdata  output  1/4/32  memory write controls
- m_req_ready  input  1  memory accepts the request
- m_resp_valid  input  1  memory response (reads and writes)
- m_resp_data  input  32  memory read data
- busy  output  1  state is not IDLE

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=IDLE, streak=0, owner=NONE, cancel=0.
  - All *_valid, *_ready and resp outputs are 0; all data/address registers are 0.
- States are IDLE, ISSUE and WAIT.
- IDLE:
  - Winner selection is combinational.
  - Grant data when d_req_valid && !(i_req_valid && streak==MAX_DATA_STREAK).
  - Otherwise grant fetch when i_req_valid && !i_flush.
  - Only the winner's *_ready is high. Ready is never high outside IDLE.
  - On acceptance: latch address/we/wstrb/wdata (fetch: we=0, wstrb=0), set owner, go to ISSUE.
- Streak counter:
  - Increment (saturating at MAX_DATA_STREAK) on a data grant while i_req_valid=1.
  - Clear on a fetch grant, or on any cycle where i_req_valid=0.
- ISSUE:
  - m_req_valid=1 and m_req_* are held stable until m_req_ready=1, then go to WAIT.
  - m_req_valid is registered: it rises the cycle after acceptance.
- WAIT:
  - On m_resp_valid, register the data and go to IDLE.
  - The owner's resp_valid pulses exactly one cycle, the cycle after m_resp_valid.
  - The response cycle is also IDLE, so a new request may be accepted in it (back-to-back throughput: accept, issue, ≥1 wait, response).
- Flush:
  - i_flush while owner=FETCH in ISSUE or WAIT sets cancel. This includes flush in the same cycle as m_resp_valid.
  - When the response arrives with cancel set: no i_resp_valid, i_resp_data unchanged, cancel cleared.
  - The memory transaction still completes; it is not aborted.
  - i_flush in IDLE blocks the fetch grant that cycle only.
  - i_flush has no effect on a data transaction.
- m_resp_valid in IDLE or ISSUE is a protocol error. It is ignored with no response pulse.
- Reset mid-transaction drops the transaction. A late m_resp_valid after reset lands in IDLE and is ignored.
- Store: d_resp_valid pulses on the memory acknowledge, with d_resp_data=0.
- i_resp_valid and d_resp_valid are never high in the same cycle.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE/ISSUE/WAIT)
  - owner encoding (NONE/FETCH/DATA)
  - STRB_ALL=4'hF
  - request struct fields: addr, we, wstrb, wdata
- One sub-module, arb_priority_select: combinational winner selection plus the saturating streak counter register.
- The top level holds the FSM, request/response registers and flush cancel.

Test Plan:
- Fetch only: i_req 0x100 at cycle 0, m_req_ready=1, m_resp_valid at cycle 3 with data 0x00500093. Expect i_req_ready at cycle 0, m_req_valid at cycle 1, i_resp_valid=1 with data 0x00500093 at cycle 4.
- Simultaneous requests: i_req 0x104 and d_req load 0x00100000 both valid, MAX_DATA_STREAK=4, d_req held valid for 6 transactions. Expect grants D,D,D,D,I,D; the fetch is served on the 5th grant.
- Store: d_req_we=1, wstrb=4'b0011, wdata=0xDEADBEEF, addr 0x00100008. Expect m_req_wstrb=0011 and m_req_wdata=0xDEADBEEF held through 2 cycles of m_req_ready=0; d_resp_valid=1 with d_resp_data=0 after the acknowledge.
- Flush: fetch 0x200 outstanding in WAIT, i_flush pulsed, then m_resp_valid. Expect no i_resp_valid, busy drops, and the next fetch 0x300 responds normally.
- Reset mid-op: reset_n=0 during ISSUE. Expect m_req_valid=0 immediately (asynchronous) and busy=0; m_resp_valid after release produces no response.
- Back-to-back data: two loads with 1-cycle memory latency. Expect the second accepted in the same cycle as the first d_resp_valid, and d_resp_valid pulses exactly 1 cycle each.
